// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serialises note events onto NUM_VOICES synth voices
// with retrigger, release-first and oldest-voice stealing, plus a linear AR envelope per voice.
module voice_allocator #(
   parameter int          NUM_VOICES   = 8,
   parameter logic [31:0] VOL_MAX      = 32'd65535,
   parameter logic [31:0] ATTACK_STEP  = 32'd4096,
   parameter logic [31:0] RELEASE_STEP = 32'd1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  note_valid,
   input  logic                  note_on,
   input  logic [6:0]            note_key,
   input  logic [31:0]           note_freq,
   output logic                  note_ready,
   input  logic                  env_tick,
   output logic [31:0]           frequencies   [NUM_VOICES],
   output logic [31:0]           voice_volumes [NUM_VOICES],
   output logic [NUM_VOICES-1:0] voice_active
);

   localparam int IDXW = $clog2(NUM_VOICES);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY} ctrl_t;
   typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} vstate_t;

   ctrl_t                 ctrlState_q;
   logic                  noteReady_q;
   logic                  tickPending_q;

   logic                  evOn_q;
   logic [6:0]            evKey_q;
   logic [31:0]           evFreq_q;

   logic [IDXW-1:0]       scanCnt_q;
   logic                  matchFound_q;
   logic [IDXW-1:0]       matchIdx_q;
   logic                  freeFound_q;
   logic [IDXW-1:0]       freeIdx_q;
   logic                  relFound_q;
   logic [IDXW-1:0]       relIdx_q;
   logic [15:0]           relAge_q;
   logic [IDXW-1:0]       oldIdx_q;
   logic [15:0]           oldAge_q;
   logic [NUM_VOICES-1:0] offMask_q;

   vstate_t               vState_q [NUM_VOICES];
   logic [6:0]            vKey_q   [NUM_VOICES];
   logic [31:0]           vFreq_q  [NUM_VOICES];
   logic [31:0]           vVol_q   [NUM_VOICES];
   logic [15:0]           vAge_q   [NUM_VOICES];

   logic                  tickApply;
   vstate_t               envState_d [NUM_VOICES];
   logic [31:0]           envVol_d   [NUM_VOICES];
   logic [32:0]           attackSum  [NUM_VOICES];
   logic [IDXW-1:0]       targetIdx;

   // Envelope step for every voice; only committed in S_IDLE, so the scan always sees stable state.
   always_comb begin
      tickApply = (ctrlState_q == S_IDLE) && (env_tick || tickPending_q);
      for (int i = 0; i < NUM_VOICES; i++) begin
         envState_d[i] = vState_q[i];
         envVol_d[i]   = vVol_q[i];
         attackSum[i]  = {1'b0, vVol_q[i]} + {1'b0, ATTACK_STEP};
         if (tickApply) begin
            case (vState_q[i])
               V_ATTACK: begin
                  if (attackSum[i] >= {1'b0, VOL_MAX}) begin
                     envVol_d[i]   = VOL_MAX;
                     envState_d[i] = V_SUSTAIN;
                  end else begin
                     envVol_d[i] = attackSum[i][31:0];
                  end
               end
               V_RELEASE: begin
                  if (vVol_q[i] <= RELEASE_STEP) begin
                     envVol_d[i]   = 32'd0;
                     envState_d[i] = V_IDLE;
                  end else begin
                     envVol_d[i] = vVol_q[i] - RELEASE_STEP;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      if (matchFound_q)     targetIdx = matchIdx_q;
      else if (freeFound_q) targetIdx = freeIdx_q;
      else if (relFound_q)  targetIdx = relIdx_q;
      else                  targetIdx = oldIdx_q;
   end

   // Control FSM and voice table: accept, scan one voice per cycle, then apply in a single cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrlState_q   <= S_IDLE;
         noteReady_q   <= 1'b1;
         tickPending_q <= 1'b0;
         evOn_q        <= 1'b0;
         evKey_q       <= '0;
         evFreq_q      <= '0;
         scanCnt_q     <= '0;
         matchFound_q  <= 1'b0;
         matchIdx_q    <= '0;
         freeFound_q   <= 1'b0;
         freeIdx_q     <= '0;
         relFound_q    <= 1'b0;
         relIdx_q      <= '0;
         relAge_q      <= '0;
         oldIdx_q      <= '0;
         oldAge_q      <= '0;
         offMask_q     <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            vState_q[i] <= V_IDLE;
            vKey_q[i]   <= '0;
            vFreq_q[i]  <= '0;
            vVol_q[i]   <= '0;
            vAge_q[i]   <= '0;
         end
      end else begin
         case (ctrlState_q)
            S_IDLE: begin
               tickPending_q <= 1'b0;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  vState_q[i] <= envState_d[i];
                  vVol_q[i]   <= envVol_d[i];
               end
               if (note_valid) begin
                  evOn_q       <= note_on;
                  evKey_q      <= note_key;
                  evFreq_q     <= note_freq;
                  scanCnt_q    <= '0;
                  matchFound_q <= 1'b0;
                  matchIdx_q   <= '0;
                  freeFound_q  <= 1'b0;
                  freeIdx_q    <= '0;
                  relFound_q   <= 1'b0;
                  relIdx_q     <= '0;
                  relAge_q     <= '0;
                  oldIdx_q     <= '0;
                  oldAge_q     <= '0;
                  offMask_q    <= '0;
                  noteReady_q  <= 1'b0;
                  ctrlState_q  <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (env_tick) tickPending_q <= 1'b1;
               if (vState_q[scanCnt_q] != V_IDLE && vKey_q[scanCnt_q] == evKey_q && !matchFound_q) begin
                  matchFound_q <= 1'b1;
                  matchIdx_q   <= scanCnt_q;
               end
               if (vState_q[scanCnt_q] == V_IDLE && !freeFound_q) begin
                  freeFound_q <= 1'b1;
                  freeIdx_q   <= scanCnt_q;
               end
               if (vState_q[scanCnt_q] == V_RELEASE && (!relFound_q || vAge_q[scanCnt_q] > relAge_q)) begin
                  relFound_q <= 1'b1;
                  relIdx_q   <= scanCnt_q;
                  relAge_q   <= vAge_q[scanCnt_q];
               end
               // Strict compare keeps the lowest index on ties; voice 0 is the implicit starting candidate.
               if (vAge_q[scanCnt_q] > oldAge_q) begin
                  oldIdx_q <= scanCnt_q;
                  oldAge_q <= vAge_q[scanCnt_q];
               end
               if ((vState_q[scanCnt_q] == V_ATTACK || vState_q[scanCnt_q] == V_SUSTAIN) &&
                   vKey_q[scanCnt_q] == evKey_q) begin
                  offMask_q[scanCnt_q] <= 1'b1;
               end
               if (scanCnt_q == IDXW'(NUM_VOICES - 1)) begin
                  ctrlState_q <= S_APPLY;
               end else begin
                  scanCnt_q <= scanCnt_q + 1'b1;
               end
            end
            S_APPLY: begin
               if (env_tick) tickPending_q <= 1'b1;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (evOn_q) begin
                     if (IDXW'(i) == targetIdx) begin
                        vKey_q[i]   <= evKey_q;
                        vFreq_q[i]  <= evFreq_q;
                        vState_q[i] <= V_ATTACK;
                        vAge_q[i]   <= '0;
                     end else if (vAge_q[i] != 16'hFFFF) begin
                        vAge_q[i] <= vAge_q[i] + 16'd1;
                     end
                  end else if (offMask_q[i]) begin
                     vState_q[i] <= V_RELEASE;
                  end
               end
               noteReady_q <= 1'b1;
               ctrlState_q <= S_IDLE;
            end
            default: ctrlState_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      voice_active = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         frequencies[i]   = vFreq_q[i];
         voice_volumes[i] = vVol_q[i];
         voice_active[i]  = (vState_q[i] != V_IDLE);
      end
   end

   assign note_ready = noteReady_q;

endmodule
